lcd_write_ctrl: RTL and testbench
=================================

# lcd_write_ctrl

Downstream consumer of the LSU's LCD register. Each store to the LCD address produces a one-cycle write strobe plus the 32-bit LCD word. The block queues these words in a small FIFO and plays each one out to an HD44780-style character LCD as a timed write cycle: setup, EN pulse, hold, then a command-dependent execution wait. It also returns a status word that the top level can map into the LSU read path.

## Interface
- FIFO_DEPTH, 4: command queue entries; power of two, ≥2.
- T_SETUP_CYC, 3: cycles RS/DATA are stable before EN rises (≥1).
- T_EN_CYC, 12: cycles EN is high (≥1).
- T_HOLD_CYC, 2: cycles RS/DATA are held after EN falls (≥1).
- T_SHORT_CYC, 2000: execution wait for normal commands and data.
- T_LONG_CYC, 82000: execution wait for clear/home commands.
- T_POWERUP_CYC, 750000: power-on delay (used only with LCD_INIT_SEQ_EN).
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- i_lcd_wr  in  1  one-cycle push strobe, generated as LSU write-enable AND LCD address decode.
- i_lcd_cmd  in  32  word layout:
  - [31] ON; [9] RS; [7:0] DATA.
  - [10] and [8] (RW) are ignored; [30:11] are ignored.
- i_ovf_clr  in  1  clears the sticky overflow flag.
- o_lcd_on  out  1  LCD power/backlight.
- o_lcd_en  out  1  LCD EN.
- o_lcd_rs  out  1  LCD RS.
- o_lcd_rw  out  1  LCD RW; tied to 0 (write-only).
- o_lcd_data  out  8  LCD data bus.
- o_busy  out  1  high when FSM ≠ IDLE or the FIFO is non-empty.
- o_ovf  out  1  sticky: a push was dropped.
- o_status  out  32  {25'b0, count[2:0], 1'b0, o_ovf, full, o_busy}; count saturates at 7.

## Operation
- FIFO entries are 10 bits {ON, RS, DATA}. A push occurs on i_lcd_wr when the FIFO is not full.
- A push while full is dropped and sets o_ovf, even if a pop happens in the same cycle.
- Push and pop in the same cycle with the FIFO non-full: both take effect and count is unchanged.
- Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop. Latch RS and DATA into the output registers and ON into o_lcd_on. Go to SETUP.
  - SETUP: lasts T_SETUP_CYC cycles, then go to PULSE.
  - PULSE: o_lcd_en=1 for T_EN_CYC cycles, then go to HOLD.
  - HOLD: lasts T_HOLD_CYC cycles, then go to WAIT.
  - WAIT: lasts T_LONG_CYC if RS=0 and DATA ∈ {0x01, 0x02, 0x03}; otherwise T_SHORT_CYC. Then go to IDLE.
- o_lcd_rs and o_lcd_data hold the last executed value until the next pop.
- A single down-counter, reloaded on every state entry and wide enough for max(T_*), times all states.
- Overflow flag: i_ovf_clr clears it. If i_ovf_clr and an overflow occur in the same cycle, o_ovf ends at 1.
- The FIFO is never bypassed: a push to an empty FIFO while IDLE is popped on the following edge.

## Timing
- Reset values: o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw = 0; o_lcd_data = 0; o_ovf = 0; FIFO empty; FSM in IDLE (or INIT, see Configuration).
- o_busy is 0 after reset without LCD_INIT_SEQ_EN.
- Reset mid-cycle (including while EN=1): every output takes its reset value at that edge and queued commands are discarded.
- Latency for a push at edge 0 into an idle, empty block:
  - edge 1: pop; RS/DATA valid.
  - edge 1+T_SETUP_CYC: EN rises.
  - edge 1+T_SETUP_CYC+T_EN_CYC: EN falls.
  - edge 1+S+E+H: WAIT begins, where S/E/H = T_SETUP_CYC/T_EN_CYC/T_HOLD_CYC.
  - edge 1+S+E+H+Twait: IDLE.
- Next pop occurs one edge after entering IDLE, so IDLE lasts ≥1 cycle.
- o_busy and o_status are registered/derived from registered state, with no combinational path from i_lcd_wr.

## Configuration
- LCD_INIT_SEQ_EN defined:
  - After reset the FSM enters INIT and waits T_POWERUP_CYC.
  - It then issues RS=0 commands 0x38, 0x0C, 0x01, 0x06 through SETUP/PULSE/HOLD/WAIT. 0x01 uses T_LONG_CYC.
  - o_lcd_on is set to 1 at the first init command.
  - User pushes are queued during init and popped only after 0x06 completes.
  - o_busy=1 throughout init.
- LCD_INIT_SEQ_EN undefined: no INIT state; the FSM starts in IDLE.

## Test plan
Bench parameters: T_SETUP_CYC=2, T_EN_CYC=4, T_HOLD_CYC=1, T_SHORT_CYC=10, T_LONG_CYC=50, FIFO_DEPTH=4.
- Push 0x8000_0241 at edge 0 → at edge 1 o_lcd_rs=1, data=0x41, on=1. EN high from edge 3 to edge 7. o_busy=0 from edge 18.
- Push 0x8000_0001 → EN pulse as above; WAIT is 50 cycles; IDLE at edge 58.
- Pushes of data 0x10..0x15 on edges 0..5 → 0x10..0x14 play out in order; 0x15 is dropped. o_ovf=1 after edge 5; o_status[1]=1 after edges 4–5.
- Assert reset while o_lcd_en=1 with 2 entries queued → next edge: en=0, data=0, o_busy=0, count=0. No further EN pulses.
- Set o_ovf, then i_ovf_clr alone → o_ovf=0. Re-fill the FIFO, then i_ovf_clr together with a dropped push → o_ovf=1.
- With LCD_INIT_SEQ_EN and T_POWERUP_CYC=20, push 0x8000_0248 during the delay → EN-rise data sequence is 0x38, 0x0C, 0x01 (long wait), 0x06, then 0x48 with RS=1.

Source files
------------

// File: rtl/lcd_write_ctrl.sv
// lcd_write_ctrl: queues LSU LCD stores and plays each out as a timed HD44780 write cycle.
// Define LCD_INIT_SEQ_EN to add a power-on delay plus controller init sequence after reset.
module lcd_write_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int T_SETUP_CYC   = 3,
    parameter int T_EN_CYC      = 12,
    parameter int T_HOLD_CYC    = 2,
    parameter int T_SHORT_CYC   = 2000,
    parameter int T_LONG_CYC    = 82000,
    parameter int T_POWERUP_CYC = 750000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_lcd_wr,
    input  logic [31:0] i_lcd_cmd,
    input  logic        i_ovf_clr,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_ovf,
    output logic [31:0] o_status
);
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int T_MAX = max_of(max_of(max_of(T_SETUP_CYC, T_EN_CYC), max_of(T_HOLD_CYC, T_SHORT_CYC)),
                                  max_of(T_LONG_CYC, T_POWERUP_CYC));
    localparam int TW = $clog2(T_MAX + 1);
    localparam logic [7:0] INIT_CMDS [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

`ifdef LCD_INIT_SEQ_EN
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;
    localparam state_t        RST_STATE = S_INIT;
    localparam logic [TW-1:0] RST_TIMER = TW'(T_POWERUP_CYC - 1);
    localparam logic          RST_INIT  = 1'b1;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;
    localparam state_t        RST_STATE = S_IDLE;
    localparam logic [TW-1:0] RST_TIMER = '0;
    localparam logic          RST_INIT  = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          on_q, on_d, en_q, en_d, rs_q, rs_d, ovf_q, ovf_d;
    logic [7:0]    data_q, data_d;
    logic          init_act_q, init_act_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic          full, empty, push, pop, done, is_long;
    logic [2:0]    count_sat;
    logic          unused_cmd_bits;

    assign full            = count_q == CW'(FIFO_DEPTH);
    assign empty           = count_q == '0;
    assign push            = i_lcd_wr && !full;
    assign done            = timer_q == '0;
    assign is_long         = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
    assign count_sat       = (32'(count_q) > 7) ? 3'd7 : 3'(count_q);
    assign unused_cmd_bits = ^{i_lcd_cmd[30:10], i_lcd_cmd[8]};

    always_comb begin
        state_d    = state_q;
        timer_d    = done ? '0 : timer_q - TW'(1);
        on_d       = on_q;
        en_d       = en_q;
        rs_d       = rs_q;
        data_d     = data_q;
        init_act_d = init_act_q;
        init_idx_d = init_idx_q;
        pop        = 1'b0;
        case (state_q)
`ifdef LCD_INIT_SEQ_EN
            S_INIT: state_d = done ? S_IDLE : S_INIT;
`endif
            S_IDLE: begin
                // Pending init commands take priority; user words stay queued until init finishes.
                if (init_act_q) begin
                    state_d    = S_SETUP;
                    timer_d    = TW'(T_SETUP_CYC - 1);
                    on_d       = 1'b1;
                    rs_d       = 1'b0;
                    data_d     = INIT_CMDS[init_idx_q];
                    init_idx_d = init_idx_q + 2'd1;
                    init_act_d = init_idx_q != 2'd3;
                end else if (!empty) begin
                    pop                  = 1'b1;
                    state_d              = S_SETUP;
                    timer_d              = TW'(T_SETUP_CYC - 1);
                    {on_d, rs_d, data_d} = mem_q[rd_q];
                end
            end
            S_SETUP: if (done) begin
                state_d = S_PULSE;
                timer_d = TW'(T_EN_CYC - 1);
                en_d    = 1'b1;
            end
            S_PULSE: if (done) begin
                state_d = S_HOLD;
                timer_d = TW'(T_HOLD_CYC - 1);
                en_d    = 1'b0;
            end
            S_HOLD: if (done) begin
                state_d = S_WAIT;
                timer_d = is_long ? TW'(T_LONG_CYC - 1) : TW'(T_SHORT_CYC - 1);
            end
            S_WAIT: state_d = done ? S_IDLE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
        mem_d = mem_q;
        if (push) mem_d[wr_q] = {i_lcd_cmd[31], i_lcd_cmd[9], i_lcd_cmd[7:0]};
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
        // A drop wins over a simultaneous clear so no overflow is ever lost.
        ovf_d   = (ovf_q && !i_ovf_clr) || (i_lcd_wr && full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RST_STATE;
            timer_q    <= RST_TIMER;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            on_q       <= 1'b0;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            init_act_q <= RST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            on_q       <= on_d;
            en_q       <= en_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            init_act_q <= init_act_d;
            init_idx_q <= init_idx_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign o_lcd_on   = on_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = data_q;
    assign o_ovf      = ovf_q;
    assign o_busy     = state_q != S_IDLE || !empty || init_act_q;
    assign o_status   = {25'b0, count_sat, 1'b0, ovf_q, full, o_busy};
endmodule

// File: tb/tb_lcd_write_ctrl.sv
// tb_lcd_write_ctrl: directed checks of queueing, write-cycle timing, overflow and reset.
// With LCD_INIT_SEQ_EN defined only the power-on init sequence is exercised.
module tb_lcd_write_ctrl;
    logic        clk = 1'b0, reset = 1'b1, i_lcd_wr = 1'b0, i_ovf_clr = 1'b0;
    logic [31:0] i_lcd_cmd = '0;
    logic        o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_busy, o_ovf;
    logic [7:0]  o_lcd_data;
    logic [31:0] o_status;
    int          n_cmp = 0, n_err = 0;
    logic [8:0]  caps [$];
    logic        en_prev = 1'b0;

    always #5 clk = ~clk;

    lcd_write_ctrl #(
        .FIFO_DEPTH(4), .T_SETUP_CYC(2), .T_EN_CYC(4), .T_HOLD_CYC(1),
        .T_SHORT_CYC(10), .T_LONG_CYC(50), .T_POWERUP_CYC(20)
    ) dut (
        .clk(clk), .reset(reset), .i_lcd_wr(i_lcd_wr), .i_lcd_cmd(i_lcd_cmd), .i_ovf_clr(i_ovf_clr),
        .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_data(o_lcd_data), .o_busy(o_busy), .o_ovf(o_ovf), .o_status(o_status)
    );

    // Record {RS, DATA} at every EN rising edge.
    always @(negedge clk) begin
        if (o_lcd_en && !en_prev) caps.push_back({o_lcd_rs, o_lcd_data});
        en_prev = o_lcd_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        i_lcd_cmd = w;
        i_lcd_wr  = 1'b1;
        tick();
        i_lcd_wr  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int i = 0; i < bound && o_busy; i++) tick();
        check(tag, 32'(o_busy), 0);
    endtask

    function automatic logic [31:0] cap_at(input int i);
        return (i < caps.size()) ? 32'(caps[i]) : 32'hDEAD;
    endfunction

`ifdef LCD_INIT_SEQ_EN
    logic [8:0] exp_init [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h148};
`endif

    initial begin
        repeat (2) tick();
        reset = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        check("init_busy", 32'(o_busy), 1);
        check("init_on_off", 32'(o_lcd_on), 0);
        repeat (5) tick();
        push(32'h8000_0248);
        check("init_on_still_off", 32'(o_lcd_on), 0);
        wait_idle("init_done", 600);
        check("init_caps_n", caps.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("init_cap%0d", i), cap_at(i), 32'(exp_init[i]));
        check("init_on", 32'(o_lcd_on), 1);
`else
        check("rst_status", o_status, 0);
        check("rst_en", 32'(o_lcd_en), 0);
        check("rst_on", 32'(o_lcd_on), 0);
        check("rst_rs", 32'(o_lcd_rs), 0);
        check("rst_rw", 32'(o_lcd_rw), 0);
        check("rst_data", 32'(o_lcd_data), 0);

        // Single data write: EN high edges 3..6, idle at edge 18.
        caps.delete();
        push(32'h8000_0241);
        for (int e = 1; e <= 18; e++) begin
            tick();
            if (e == 1) begin
                check("t1_rs", 32'(o_lcd_rs), 1);
                check("t1_data", 32'(o_lcd_data), 32'h41);
                check("t1_on", 32'(o_lcd_on), 1);
            end
            check($sformatf("t1_en@%0d", e), 32'(o_lcd_en), 32'(e >= 3 && e < 7));
            check($sformatf("t1_busy@%0d", e), 32'(o_busy), 32'(e < 18));
        end
        check("t1_hold_data", 32'(o_lcd_data), 32'h41);
        check("t1_caps", caps.size(), 1);

        // Clear display: long execution wait, idle at edge 58.
        caps.delete();
        push(32'h8000_0001);
        for (int e = 1; e <= 58; e++) begin
            tick();
            if (e == 1) begin
                check("t2_rs", 32'(o_lcd_rs), 0);
                check("t2_data", 32'(o_lcd_data), 32'h01);
            end
            check($sformatf("t2_en@%0d", e), 32'(o_lcd_en), 32'(e >= 3 && e < 7));
            if (e >= 56) check($sformatf("t2_busy@%0d", e), 32'(o_busy), 32'(e < 58));
        end

        // Burst of six pushes into a four-deep queue.
        caps.delete();
        for (int k = 0; k <= 5; k++) begin
            push(32'h8000_0210 + 32'(k));
            check($sformatf("t3_full@%0d", k), 32'(o_status[1]), 32'(k >= 4));
            check($sformatf("t3_ovf@%0d", k), 32'(o_ovf), 32'(k == 5));
        end
        wait_idle("t3_drain", 300);
        check("t3_caps_n", caps.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("t3_cap%0d", i), cap_at(i), 32'h110 + 32'(i));
        check("t3_ovf_sticky", 32'(o_ovf), 1);

        // Overflow clear alone, then clear colliding with a dropped push.
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        check("t5_clr", 32'(o_ovf), 0);
        for (int k = 0; k <= 4; k++) push(32'h8000_0230 + 32'(k));
        check("t5_status_full", o_status, 32'h43);
        i_ovf_clr = 1'b1;
        push(32'h8000_0235);
        i_ovf_clr = 1'b0;
        check("t5_ovf_wins", 32'(o_ovf), 1);
        check("t5_status_ovf", o_status, 32'h47);
        wait_idle("t5_drain", 300);

        // Reset while EN is high with two entries queued; ignored command bits.
        caps.delete();
        push(32'h7FFF_FD41);
        push(32'h8000_0242);
        check("t4_ign_on", 32'(o_lcd_on), 0);
        check("t4_ign_rs", 32'(o_lcd_rs), 0);
        check("t4_ign_data", 32'(o_lcd_data), 32'h41);
        push(32'h8000_0243);
        tick();
        check("t4_en_pre", 32'(o_lcd_en), 1);
        check("t4_status_pre", o_status, 32'h25);
        reset = 1'b1;
        tick();
        check("t4_en", 32'(o_lcd_en), 0);
        check("t4_data", 32'(o_lcd_data), 0);
        check("t4_busy", 32'(o_busy), 0);
        check("t4_status", o_status, 0);
        check("t4_on", 32'(o_lcd_on), 0);
        reset = 1'b0;
        repeat (100) tick();
        check("t4_no_pulse", caps.size(), 1);
        check("t4_busy_after", 32'(o_busy), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
